// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//
// Pops 16-bit words from the head of a first-word-fall-through FIFO and packs
// consecutive pairs into 32-bit words on a valid/ready output stream. The first
// popped word lands in out_data[15:0] and the second in out_data[31:16]. While
// the sink accepts every word it sustains one pop per cycle.
//
// Optional feature (macro PACK_TIMEOUT_EN): a lone half-word that has waited
// TIMEOUT idle cycles is flushed as {16'h0, low} with out_half=1. Without the
// macro, no counter is built and out_half is always 0.
//
// Parameters:
//   TIMEOUT     idle cycles in HALF before a flush (1..255, timeout build only)
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO head word, valid whenever fifo_empty=0
//   fifo_rd_en  pop request (combinational); FIFO must honour it when not empty
//   out_valid   out_data holds a packed word
//   out_ready   sink accepts the word this cycle
//   out_data    packed word
//   out_half    only out_data[15:0] is meaningful (timeout flush)

module fifo_word_packer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_data,
    output logic        fifo_rd_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_half
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,  // nothing held
        S_HALF  = 2'd1,  // low half waiting for its partner
        S_FULL  = 2'd2   // packed word presented on the output
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] low_q, low_nxt;
    logic [31:0] data_nxt;
    logic        half_nxt;
    logic        pop;
    logic        expire;

    // A pop may happen in FULL only when the held word leaves this same cycle,
    // which is what keeps the stream bubble-free.
    assign pop        = !rst && !fifo_empty && ((state != S_FULL) || out_ready);
    assign fifo_rd_en = pop;
    assign out_valid  = (state == S_FULL);

`ifdef PACK_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_nxt;

    assign expire = (state == S_HALF) && (cnt_q == 8'(TIMEOUT));

    // Clears whenever HALF is (re)entered, counts idle HALF cycles otherwise.
    always_comb begin
        cnt_nxt = cnt_q;
        if ((state_nxt == S_HALF) && (state != S_HALF)) begin
            cnt_nxt = 8'd0;
        end else if ((state == S_HALF) && !pop) begin
            cnt_nxt = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end
`else
    // HALF waits indefinitely; TIMEOUT has no effect in this build.
    assign expire = 1'b0 && (TIMEOUT != 0);
`endif

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        low_nxt   = low_q;
        data_nxt  = out_data;
        half_nxt  = out_half;
        unique case (state)
            S_EMPTY: begin
                if (pop) begin
                    low_nxt   = fifo_data;
                    state_nxt = S_HALF;
                end
            end
            S_HALF: begin
                // A pop in the expiry cycle wins and forms a normal word.
                if (pop) begin
                    data_nxt  = {fifo_data, low_q};
                    half_nxt  = 1'b0;
                    state_nxt = S_FULL;
                end else if (expire) begin
                    data_nxt  = {16'h0000, low_q};
                    half_nxt  = 1'b1;
                    state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                // Without out_ready everything holds, keeping out_data stable.
                if (out_ready) begin
                    if (pop) begin
                        low_nxt   = fifo_data;
                        state_nxt = S_HALF;
                    end else begin
                        state_nxt = S_EMPTY;
                    end
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_EMPTY;
            low_q    <= 16'h0000;
            out_data <= 32'h0000_0000;
            out_half <= 1'b0;
        end else begin
            state    <= state_nxt;
            low_q    <= low_nxt;
            out_data <= data_nxt;
            out_half <= half_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer.
// The FIFO is a queue of words; the reference model pairs popped words in pop
// order (dropping a held half on reset) and, in the timeout build, flushes a
// lone half after the allowed idle time. Directed cases cover latency,
// throughput, backpressure, reset mid-packet and timeout; a randomized phase
// follows with random FIFO gaps, sink stalls and occasional resets.
`timescale 1ns/1ps

module tb_fifo_word_packer;

`ifdef PACK_TIMEOUT_EN
    localparam int TO = 3;
`else
    localparam int TO = 15;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_rd_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_half;

    always #5 clk = ~clk;

    fifo_word_packer #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_half   (out_half)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic        half;
    } word_t;

    logic [15:0] src_q[$];     // FIFO contents, head at index 0
    word_t       exp_q[$];     // words the DUT should be presenting/has formed
    bit          pend;         // model holds a lone half-word
    logic [15:0] pend_w;
    int          idle;         // idle cycles the lone half has waited
    int          cyc = 0;
    int          pop_cyc[$];
    int          val_cyc[$];
    int          hs_cyc[$];
    logic [31:0] hs_data[$];
    logic        hs_half[$];
    int          empty_pct = 0;
    int          ready_pct = 100;
    int          words_formed = 0;
    int          words_taken = 0;

    task automatic clear_logs();
        pop_cyc.delete();
        val_cyc.delete();
        hs_cyc.delete();
        hs_data.delete();
        hs_half.delete();
    endtask

    // One clock cycle: drive inputs on the falling edge, check, update model.
    task automatic cycle(input bit r = 1'b0);
        bit          exp_valid;
        bit          popped;
        logic [15:0] w;
        @(negedge clk);
        rst        = r;
        fifo_empty = (src_q.size() == 0) || ($urandom_range(99) < empty_pct);
        fifo_data  = (src_q.size() != 0) ? src_q[0] : 16'($urandom);
        out_ready  = ($urandom_range(99) < ready_pct);
        #1;
        exp_valid = (exp_q.size() != 0);
        check("out_valid", out_valid, exp_valid);
        check("rd_en_rule", fifo_rd_en, !r && !fifo_empty && (!exp_valid || out_ready));
        if (exp_valid) begin
            check("out_data", out_data, exp_q[0].data);
            check("out_half", out_half, exp_q[0].half);
        end
        if (out_valid) val_cyc.push_back(cyc);
        if (out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            hs_data.push_back(out_data);
            hs_half.push_back(out_half);
            words_taken++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        popped = fifo_rd_en && !fifo_empty && (src_q.size() != 0);
        if (r) begin
            exp_q.delete();
            pend = 1'b0;
        end else if (popped) begin
            w = src_q.pop_front();
            pop_cyc.push_back(cyc);
            if (pend) begin
                exp_q.push_back('{data: {w, pend_w}, half: 1'b0});
                words_formed++;
                pend = 1'b0;
            end else begin
                pend   = 1'b1;
                pend_w = w;
                idle   = 0;
            end
        end else if (pend) begin
`ifdef PACK_TIMEOUT_EN
            if (idle == TO) begin
                exp_q.push_back('{data: {16'h0000, pend_w}, half: 1'b1});
                words_formed++;
                pend = 1'b0;
            end else begin
                idle++;
            end
`endif
        end
        cyc++;
    endtask

    task automatic post_reset_check(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_data"}, out_data, 32'h0);
        check({tag, "_half"}, out_half, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int held;
        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 16'h0;
        out_ready  = 1'b0;
        pend       = 1'b0;
        idle       = 0;

        // Reset state
        cycle(1'b1);
        cycle(1'b1);
        post_reset_check("reset");

        // Two preloaded words: two consecutive pops, one output word
        clear_logs();
        src_q = '{16'h1111, 16'h2222};
        repeat (6) cycle();
        check("t1_pops", pop_cyc.size(), 2);
        check("t1_valid_cycles", val_cyc.size(), 1);
        if (pop_cyc.size() == 2 && val_cyc.size() == 1) begin
            check("t1_pop_gap", pop_cyc[1] - pop_cyc[0], 1);
            check("t1_latency", val_cyc[0] - pop_cyc[0], 2);
        end
        if (hs_data.size() == 1) begin
            check("t1_word", hs_data[0], 32'h2222_1111);
            check("t1_half", hs_half[0], 1'b0);
        end

        // Eight streamed words: back-to-back pops, one word every 2 cycles
        clear_logs();
        for (int i = 1; i <= 8; i++) src_q.push_back(16'(i));
        repeat (14) cycle();
        check("t2_pops", pop_cyc.size(), 8);
        check("t2_words", hs_cyc.size(), 4);
        if (pop_cyc.size() == 8) check("t2_pop_span", pop_cyc[7] - pop_cyc[0], 7);
        if (pop_cyc.size() == 8 && hs_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("t2_hs_cycle", hs_cyc[k] - pop_cyc[0], 2 * k + 2);
                check("t2_word", hs_data[k], {16'(2 * k + 2), 16'(2 * k + 1)});
            end
        end

        // Backpressure: FULL held 5 cycles with FIFO non-empty
        clear_logs();
        ready_pct = 0;
        src_q = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        for (int i = 0; i < 10 && !out_valid; i++) cycle();
        check("t3_full", out_valid, 1'b1);
        held = pop_cyc.size();
        repeat (5) cycle();
        check("t3_no_pop_while_full", pop_cyc.size() - held, 0);
        check("t3_fifo_untouched", src_q.size(), 2);
        ready_pct = 100;
        cycle();
        if (hs_cyc.size() >= 1 && pop_cyc.size() >= 1)
            check("t3_pop_with_handshake", pop_cyc[pop_cyc.size() - 1], hs_cyc[0]);
        else
            check("t3_handshake_seen", hs_cyc.size(), 1);
        repeat (4) cycle();
        check("t3_words", hs_data.size(), 2);
        if (hs_data.size() == 2) check("t3_word2", hs_data[1], 32'h00A3_00A2);

        // Reset while HALF holds 16'hABCD: the half is discarded
        clear_logs();
        src_q = '{16'hABCD};
        cycle();
        src_q.push_back(16'h0005);
        src_q.push_back(16'h0006);
        cycle(1'b1);
        post_reset_check("t4_reset");
        repeat (5) cycle();
        check("t4_words", hs_data.size(), 1);
        if (hs_data.size() == 1) check("t4_word", hs_data[0], 32'h0006_0005);

`ifdef PACK_TIMEOUT_EN
        // Lone word flushed as a half after TIMEOUT idle cycles
        clear_logs();
        src_q = '{16'h00AA};
        cycle();
        p = pop_cyc.size() ? pop_cyc[0] : cyc;
        repeat (TO + 4) cycle();
        check("t5_valid_cycles", val_cyc.size(), 1);
        if (val_cyc.size() == 1) check("t5_flush_cycle", val_cyc[0] - p, TO + 2);
        if (hs_data.size() == 1) begin
            check("t5_word", hs_data[0], 32'h0000_00AA);
            check("t5_half", hs_half[0], 1'b1);
        end

        // Second word arrives exactly in the expiry cycle: full word wins
        clear_logs();
        src_q = '{16'h00BB};
        cycle();
        repeat (TO) cycle();
        src_q.push_back(16'h00CC);
        cycle();
        repeat (3) cycle();
        check("t6_words", hs_data.size(), 1);
        if (hs_data.size() == 1) begin
            check("t6_word", hs_data[0], 32'h00CC_00BB);
            check("t6_half", hs_half[0], 1'b0);
        end
`endif

        // Randomized traffic with FIFO gaps, sink stalls and rare resets
        empty_pct = 30;
        ready_pct = 60;
        for (int i = 0; i < 600; i++) begin
            while (src_q.size() < 4) src_q.push_back(16'($urandom));
            cycle($urandom_range(199) == 0);
        end

        // Drain: sink always ready, no more input
        empty_pct = 0;
        ready_pct = 100;
        src_q.delete();
        repeat (TO + 10) cycle();
        check("drain_outstanding", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
